// File: rtl/enemy_squad_pkg.sv
// Shared types, screen limits and the add-only span test used by the enemy squad.
package enemy_squad_pkg;

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        EXPLODE = 2'd1,
        DEAD    = 2'd2
    } enemy_state_t;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // True when a lies strictly within half of c; widened so neither side wraps.
    function automatic logic in_span(input logic [9:0] a, input logic [9:0] c,
                                     input logic [9:0] half);
        return (({1'b0, a} + {1'b0, half}) > {1'b0, c}) &&
               ({1'b0, a} < ({1'b0, c} + {1'b0, half}));
    endfunction

endpackage

// File: rtl/enemy_squad_if.sv
// Frame, bullet, scan and status signals between the squad and the game core.
interface enemy_squad_if
    import enemy_squad_pkg::*;
#(
    parameter int N_ENEMY = 4
);
    logic               frameTick;
    logic               bulletValid;
    logic [9:0]         bulletPosX;
    logic [9:0]         bulletPosY;
    logic [9:0]         horCnt;
    logic [9:0]         verCnt;
    logic               hitPulse;
    logic [2:0]         hitIndex;
    logic [N_ENEMY-1:0] aliveMask;
    logic               allDead;
    logic [9:0]         posX;
    logic [9:0]         posY;
    logic [5:0]         rgbContentEnemy;

    modport slave (
        input  frameTick, bulletValid, bulletPosX, bulletPosY, horCnt, verCnt,
        output hitPulse, hitIndex, aliveMask, allDead, posX, posY, rgbContentEnemy
    );

    modport master (
        output frameTick, bulletValid, bulletPosX, bulletPosY, horCnt, verCnt,
        input  hitPulse, hitIndex, aliveMask, allDead, posX, posY, rgbContentEnemy
    );
endinterface

// File: rtl/enemy_squad_sprite_rom.sv
// Two-frame 16x16 enemy bitmap; bit k of a row is sprite column k.
module enemy_sprite_rom
    import enemy_squad_pkg::*;
(
    input  logic        frame,
    input  logic [3:0]  row,
    output logic [15:0] row_bits
);
    always_comb begin
        row_bits = 16'h0000;
        case (row)
            4'd2:    row_bits = 16'h1010;
            4'd3:    row_bits = 16'h0820;
            4'd4:    row_bits = 16'h1FF0;
            4'd5:    row_bits = 16'h3BB8;
            4'd6:    row_bits = 16'h7FFC;
            4'd7:    row_bits = 16'h5FF4;
            4'd8:    row_bits = 16'h7FFE;
            4'd9:    row_bits = frame ? 16'h2828 : 16'h5014;
            4'd10:   row_bits = frame ? 16'h4444 : 16'h0C60;
            default: row_bits = 16'h0000;
        endcase
    end
endmodule

// File: rtl/enemy_squad.sv
// Row of marching enemies: per-enemy life FSM, bullet hit arbitration,
// rim-bounce movement and a registered pixel output.
module enemy_squad
    import enemy_squad_pkg::*;
#(
    parameter int N_ENEMY     = 4,
    parameter int SPACING     = 40,
    parameter int HALF_W      = 8,
    parameter int HALF_H      = 8,
    parameter int STEP        = 2,
    parameter int MOVE_TICKS  = 4,
    parameter int DROP        = 8,
    parameter int EXPL_FRAMES = 8,
    parameter int iPosX       = 69,
    parameter int iPosY       = 40,
    parameter int leftRim     = 9,
    parameter int rightRim    = 630,
    parameter logic [5:0] COLOR      = 6'b000011,
    parameter logic [5:0] EXPL_COLOR = 6'b110000
)(
    input logic          clk,
    input logic          reset,
    enemy_squad_if.slave bus
);
    localparam int MW    = $clog2(MOVE_TICKS + 1);
    localparam int EW    = $clog2(EXPL_FRAMES + 1);
    localparam int Y_MAX = SCREEN_H - 1 - HALF_H;

    logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    dir_t          dir_q, dir_d;
    logic [MW-1:0] move_cnt_q, move_cnt_d;
    logic          anim_q, anim_d;
    logic          lock_q, lock_d;
    logic          hit_pulse_q, hit_pulse_d;
    logic [2:0]    hit_index_q, hit_index_d;
    logic [5:0]    rgb_q, rgb_d;

    logic [N_ENEMY-1:0][9:0] centre_x;
    logic [N_ENEMY-1:0][3:0] pix_col;
    logic [N_ENEMY-1:0]      alive, live, cand, pix_hit, win_oh;
    logic [2:0]  win_idx;
    logic        cand_any, accept, all_dead, pix_any, pix_alive;
    logic [9:0]  hi_c, lo_c, drop_y;
    logic [3:0]  pix_row, col_sel;
    logic [15:0] rom_bits;

    genvar gi;
    generate
        for (gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
            enemy_state_t  state_q, state_d;
            logic [EW-1:0] expl_cnt_q, expl_cnt_d;

            assign centre_x[gi] = pos_x_q + 10'(gi * SPACING);
            assign alive[gi]    = (state_q == ALIVE);
            assign live[gi]     = (state_q != DEAD);
            assign cand[gi]     = bus.bulletValid && alive[gi] &&
                                  in_span(bus.bulletPosX, centre_x[gi], 10'(HALF_W)) &&
                                  in_span(bus.bulletPosY, pos_y_q, 10'(HALF_H));
            assign pix_hit[gi]  = live[gi] &&
                                  in_span(bus.horCnt, centre_x[gi], 10'(HALF_W)) &&
                                  in_span(bus.verCnt, pos_y_q, 10'(HALF_H));
            // Only the low nibble of the column offset is needed to address the ROM.
            assign pix_col[gi]  = bus.horCnt[3:0] + 4'(HALF_W) - centre_x[gi][3:0];

            always_comb begin
                state_d    = state_q;
                expl_cnt_d = expl_cnt_q;
                case (state_q)
                    ALIVE: if (accept && win_oh[gi]) begin
                        state_d    = EXPLODE;
                        expl_cnt_d = '0;
                    end
                    EXPLODE: if (bus.frameTick) begin
                        if (expl_cnt_q == EW'(EXPL_FRAMES - 1)) begin
                            state_d    = DEAD;
                            expl_cnt_d = '0;
                        end else begin
                            expl_cnt_d = expl_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    state_q    <= ALIVE;
                    expl_cnt_q <= '0;
                end else begin
                    state_q    <= state_d;
                    expl_cnt_q <= expl_cnt_d;
                end
            end
        end
    endgenerate

    // Lowest index wins for hits, leftmost live enemy and pixel ownership.
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        cand_any  = 1'b0;
        lo_c      = centre_x[0];
        hi_c      = centre_x[0];
        pix_any   = 1'b0;
        pix_alive = 1'b0;
        col_sel   = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_idx   = 3'(i);
                cand_any  = 1'b1;
            end
            if (live[i]) lo_c = centre_x[i];
            if (pix_hit[i]) begin
                pix_any   = 1'b1;
                pix_alive = alive[i];
                col_sel   = pix_col[i];
            end
        end
        for (int i = 0; i < N_ENEMY; i++) begin
            if (live[i]) hi_c = centre_x[i];
        end
    end

    assign accept   = cand_any && !lock_q;
    assign all_dead = ~|live;
    assign pix_row  = bus.verCnt[3:0] + 4'(HALF_H) - pos_y_q[3:0];
    assign drop_y   = (({1'b0, pos_y_q} + 11'(DROP)) > 11'(Y_MAX)) ? 10'(Y_MAX)
                                                                 : pos_y_q + 10'(DROP);

    enemy_sprite_rom u_rom (
        .frame    (anim_q),
        .row      (pix_row),
        .row_bits (rom_bits)
    );

    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_d       = dir_q;
        move_cnt_d  = move_cnt_q;
        anim_d      = anim_q;
        lock_d      = bus.bulletValid && (lock_q || accept);
        hit_pulse_d = accept;
        hit_index_d = accept ? win_idx : hit_index_q;
        rgb_d       = 6'b000000;
        if (bus.frameTick && !all_dead) begin
            if (move_cnt_q == MW'(MOVE_TICKS - 1)) begin
                move_cnt_d = '0;
                anim_d     = ~anim_q;
                if (dir_q == RIGHT) begin
                    if (({1'b0, hi_c} + 11'(HALF_W + STEP)) > 11'(rightRim)) begin
                        pos_y_d = drop_y;
                        dir_d   = LEFT;
                    end else begin
                        pos_x_d = pos_x_q + 10'(STEP);
                    end
                end else begin
                    if ({1'b0, lo_c} < 11'(leftRim + HALF_W + STEP)) begin
                        pos_y_d = drop_y;
                        dir_d   = RIGHT;
                    end else begin
                        pos_x_d = pos_x_q - 10'(STEP);
                    end
                end
            end else begin
                move_cnt_d = move_cnt_q + 1'b1;
            end
        end
        if (pix_any && rom_bits[col_sel]) begin
            rgb_d = pix_alive ? COLOR : EXPL_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_x_q     <= 10'(iPosX);
            pos_y_q     <= 10'(iPosY);
            dir_q       <= RIGHT;
            move_cnt_q  <= '0;
            anim_q      <= 1'b0;
            lock_q      <= 1'b0;
            hit_pulse_q <= 1'b0;
            hit_index_q <= '0;
            rgb_q       <= '0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            move_cnt_q  <= move_cnt_d;
            anim_q      <= anim_d;
            lock_q      <= lock_d;
            hit_pulse_q <= hit_pulse_d;
            hit_index_q <= hit_index_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.hitPulse        = hit_pulse_q;
    assign bus.hitIndex        = hit_index_q;
    assign bus.aliveMask       = alive;
    assign bus.allDead         = all_dead;
    assign bus.posX            = pos_x_q;
    assign bus.posY            = pos_y_q;
    assign bus.rgbContentEnemy = rgb_q;

endmodule

// File: doc/enemy_squad.md
ENEMY_SQUAD -- requirements
Module: enemy_squad

Interface
REQ-001 Parameters (name, default, meaning): N_ENEMY, 4, enemies in the row (1..8); SPACING, 40, x pitch between enemy centres; HALF_W, 8, half sprite width; HALF_H, 8, half sprite height; STEP, 2, x pixels per move; MOVE_TICKS, 4, frames per move; DROP, 8, y pixels per rim bounce; EXPL_FRAMES, 8, explosion duration in frames; iPosX, 69, reset x of enemy 0; iPosY, 40, reset y; leftRim, 9; rightRim, 630; COLOR, 6'b000011, sprite colour; EXPL_COLOR, 6'b110000, explosion colour.
REQ-002 clk  in  1  system clock; all state on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 frameTick  in  1  one-cycle pulse per video frame.
REQ-005 bulletValid  in  1  player bullet is in flight.
REQ-006 bulletPosX, bulletPosY  in  10 each  bullet centre.
REQ-007 horCnt, verCnt  in  10 each  current scan pixel.
REQ-008 hitPulse  out  1  one-cycle pulse on an accepted hit; also consumes the bullet.
REQ-009 hitIndex  out  3  index of the enemy hit; held until the next hit.
REQ-010 aliveMask  out  N_ENEMY  bit i = enemy i in ALIVE.
REQ-011 allDead  out  1  no enemy in ALIVE or EXPLODE.
REQ-012 posX, posY  out  10 each  squad base, i.e. centre of enemy 0.
REQ-013 rgbContentEnemy  out  6  pixel colour, 6'b000000 = transparent.

Function
REQ-014 Enemy i centre SHALL be (posX + i*SPACING, posY); all geometry is 10-bit unsigned.
REQ-015 Every comparison SHALL be written in add-only form (a + HALF_W > c, a < c + HALF_W) so no operand wraps below zero.
REQ-016 Each enemy SHALL run its own FSM: ALIVE -> EXPLODE on an accepted hit; EXPLODE -> DEAD after EXPL_FRAMES frameTicks; DEAD is terminal until reset.
REQ-017 A hit candidate SHALL require bulletValid=1, the enemy in ALIVE, and the bullet strictly inside the HALF_W x HALF_H box around its centre.
REQ-018 When several enemies are candidates in the same cycle, the lowest index SHALL win; only one hit is accepted per cycle.
REQ-019 After an accepted hit, hitPulse SHALL be 1 in the next cycle, hitIndex SHALL update in that same cycle, and no further hit is accepted while bulletValid remains 1 (re-arm on bulletValid=0).
REQ-020 Movement FSM states: RIGHT, LEFT. A move counter SHALL count frameTicks; on reaching MOVE_TICKS it clears and the squad steps STEP in the current direction.
REQ-021 Before stepping RIGHT, if the rightmost live enemy's right edge + STEP > rightRim, the squad SHALL instead add DROP to posY and switch to LEFT; LEFT mirrors this against leftRim using the leftmost live enemy.
REQ-022 Rim checks SHALL use only ALIVE/EXPLODE enemies; when allDead=1, movement SHALL freeze.
REQ-023 posY SHALL saturate at 479 - HALF_H.
REQ-024 Rendering SHALL be registered with one-cycle latency. The pixel matches enemy i when horCnt lies strictly inside its x-span and verCnt strictly inside its y-span.
REQ-025 Sprite row = verCnt + HALF_H - posY; column = horCnt + HALF_W - centre_i.
REQ-026 A lit bit SHALL output COLOR for ALIVE and EXPL_COLOR for EXPLODE; DEAD enemies and unlit bits output 0. Overlapping matches resolve to the lowest index.
REQ-027 Two sprite frames SHALL alternate on every move step, giving a walk animation.

Reset
REQ-028 On reset=0 at a clock edge: posX=iPosX, posY=iPosY, direction RIGHT, counters 0, every enemy ALIVE, hitPulse=0, hitIndex=0, rgbContentEnemy=0, and the hit lock released.
REQ-029 Reset SHALL override simultaneous frameTick and hit events, and SHALL restore the squad fully in mid-explosion or mid-move.

Structure
REQ-030 A shared package SHALL hold the enemy state enum (ALIVE, EXPLODE, DEAD), the direction enum, and the screen limits 640/480.
REQ-031 One sub-module, enemy_sprite_rom, SHALL provide a combinational 16-bit row from (frame, row[3:0]); the same instance is shared by all enemies through the pixel mux.
REQ-032 With N_ENEMY=1 the module SHALL behave correctly, rim checks included.

Verification
REQ-033 Reset, then 4 frameTicks -> posX=71, posY=40, aliveMask=4'b1111.
REQ-034 Bullet at (69+40+3, 42) with bulletValid=1 -> hitPulse one cycle, hitIndex=1, aliveMask=4'b1101. Bullet held there: no second pulse.
REQ-035 Bullet equidistant inside the overlapping boxes of enemies 2 and 3 (SPACING=12) -> hitIndex=2 only.
REQ-036 Drive the squad until enemy 3's right edge + 2 > 630 -> next step posX unchanged, posY+8, direction LEFT; kill enemy 3 -> bounce is computed from enemy 2.
REQ-037 Hit enemy 0, then give 8 frameTicks -> EXPL_COLOR pixels on frames 1-8, transparent afterwards; after killing all four, allDead=1 and movement is frozen.
REQ-038 Assert reset=0 mid-explosion -> next cycle all outputs are at their reset values.
